// File: rtl/he_lut_apply.sv
// Histogram-equalization LUT applier: loads a MAX_VALUE-entry mapping table from the
// HE calculator stream, then remaps one frame of pixels onto a valid/ready output.
module he_lut_apply #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 21,
    parameter int MAX_VALUE = 256,
    parameter int TOTAL_PIX = 1091840
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              lut_valid,
    input  logic [AWIDTH-1:0] lut_in,
    input  logic              pix_valid,
    input  logic [DWIDTH-1:0] pix_in,
    output logic              pix_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_pix,
    input  logic              out_ready,
    output logic              done,
    output logic [3:0]        state
);

    localparam int LCW = $clog2(MAX_VALUE) + 1;
    localparam logic [LCW-1:0]    LUT_LAST   = LCW'(MAX_VALUE - 1);
    localparam logic [AWIDTH-1:0] SAT_MAX    = AWIDTH'(MAX_VALUE - 1);
    localparam logic [AWIDTH-1:0] PIX_TOTAL  = AWIDTH'(TOTAL_PIX);
    localparam logic [AWIDTH-1:0] FRAME_LAST = AWIDTH'(TOTAL_PIX - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_LOAD = 4'b0010,
        S_RUN  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t state_q, state_d;

    logic [LCW-1:0]    lut_cnt;
    logic [AWIDTH-1:0] pix_cnt;
    logic [AWIDTH-1:0] out_cnt;
    logic [DWIDTH-1:0] lut [MAX_VALUE];
    logic [DWIDTH-1:0] lut_sat;
    logic              in_hs;
    logic              out_hs;

    always_comb begin
        pix_ready = (state_q == S_RUN) && (pix_cnt < PIX_TOTAL) && (!out_valid || out_ready);
        in_hs     = pix_valid && pix_ready;
        out_hs    = (state_q == S_RUN) && out_valid && out_ready;
        lut_sat   = (lut_in > SAT_MAX) ? DWIDTH'(MAX_VALUE - 1) : lut_in[DWIDTH-1:0];
        done      = (state_q == S_DONE);
        state     = state_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: if (lut_valid && lut_cnt == LUT_LAST) state_d = S_RUN;
            S_RUN:  if (out_hs && out_cnt == FRAME_LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Table has no reset: contents are meaningless until a full load completes.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && lut_valid)
            lut[lut_cnt[LCW-2:0]] <= lut_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lut_cnt   <= '0;
            pix_cnt   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) lut_cnt <= '0;
                S_LOAD: begin
                    if (lut_valid) begin
                        lut_cnt <= lut_cnt + LCW'(1);
                        if (lut_cnt == LUT_LAST) begin
                            pix_cnt <= '0;
                            out_cnt <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // A new input overrides the drain so the output register never bubbles.
                    if (in_hs) begin
                        out_pix   <= lut[pix_in];
                        out_valid <= 1'b1;
                        pix_cnt   <= pix_cnt + AWIDTH'(1);
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                    end
                    if (out_hs) out_cnt <= out_cnt + AWIDTH'(1);
                end
                S_DONE: out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_he_lut_apply.sv
// Directed bench for he_lut_apply with a 16-pixel frame; a negedge monitor keeps
// a scoreboard of expected remapped pixels pushed on input and popped on output.
module tb_he_lut_apply;

    localparam int DW = 8;
    localparam int AW = 21;
    localparam int NPIX = 16;

    logic          clk = 1'b0;
    logic          reset, start, lut_valid, pix_valid, out_ready;
    logic [AW-1:0] lut_in;
    logic [DW-1:0] pix_in;
    logic          pix_ready, out_valid, done;
    logic [DW-1:0] out_pix;
    logic [3:0]    state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] model [256];
    logic [7:0] sb_q [$];

    he_lut_apply #(
        .DWIDTH(DW), .AWIDTH(AW), .MAX_VALUE(256), .TOTAL_PIX(NPIX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .lut_valid(lut_valid), .lut_in(lut_in),
        .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
        .out_valid(out_valid), .out_pix(out_pix), .out_ready(out_ready),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: retire output handshakes first, then record the input handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_unexpected_out", 32'(out_pix), 32'hFFFF_FFFF);
                else check("sb_out", 32'(out_pix), 32'(sb_q.pop_front()));
            end
            if (pix_valid && pix_ready) sb_q.push_back(model[pix_in]);
        end
    end

    function automatic int lut_val(input int mode, input int i);
        case (mode)
            0: return i;
            1: return (i == 10) ? 1000 : 255 - i;
            2: return (i * 7 + 3) % 256;
            default: return i * 3;
        endcase
    endfunction

    task automatic load_lut(input int mode, input bit stall);
        int v;
        int c0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_enter", 32'(state), 32'h2);
        c0 = cyc;
        for (int i = 0; i < 256; i++) begin
            v = lut_val(mode, i);
            model[i] = (v > 255) ? 8'd255 : 8'(v);
            lut_valid = 1'b1;
            lut_in = AW'(v);
            @(posedge clk); #1;
            if (i == 254) check("load_hold", 32'(state), 32'h2);
            if (stall && i != 255) begin
                lut_valid = 1'b0;
                lut_in = '1;
                repeat (2) begin @(posedge clk); #1; end
                if (i == 254) check("load_stall_hold", 32'(state), 32'h2);
            end
        end
        lut_valid = 1'b0;
        check("load_cycles", 32'(cyc - c0), stall ? 32'(256 + 255 * 2) : 32'd256);
        check("load_exit", 32'(state), 32'h4);
    endtask

    task automatic send_pix(input logic [7:0] p);
        bit ok = 1'b0;
        pix_valid = 1'b1;
        pix_in = p;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input bit check_blocked, output int done_cyc);
        bit seen = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (check_blocked) check("no_extra_pix", 32'(pix_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("done_state", 32'(state), 32'h8);
            check("done_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(state), 32'h1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int dc;
        int c0;
        reset = 1'b1; start = 1'b0; lut_valid = 1'b0; lut_in = '0;
        pix_valid = 1'b0; pix_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pix", 32'(out_pix), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        reset = 1'b0;

        // 1: identity table, one-cycle latency
        load_lut(0, 1'b0);
        send_pix(8'd0);   check("id_valid_0", 32'(out_valid), 32'd1); check("id_pix_0", 32'(out_pix), 32'd0);
        send_pix(8'd17);  check("id_valid_17", 32'(out_valid), 32'd1); check("id_pix_17", 32'(out_pix), 32'd17);
        send_pix(8'd255); check("id_valid_255", 32'(out_valid), 32'd1); check("id_pix_255", 32'(out_pix), 32'd255);
        for (int i = 0; i < NPIX - 3; i++) send_pix(8'($urandom_range(0, 255)));
        wait_done(1'b0, dc);

        // 2: inverted table with one saturating entry, then 3: backpressure
        load_lut(1, 1'b0);
        send_pix(8'd10);  check("sat_pix_10", 32'(out_pix), 32'd255);
        send_pix(8'd0);   check("inv_pix_0", 32'(out_pix), 32'd255);
        send_pix(8'd200); check("inv_pix_200", 32'(out_pix), 32'd55);
        send_pix(8'd213); check("bp_pix_42", 32'(out_pix), 32'd42);
        out_ready = 1'b0;
        pix_valid = 1'b1;
        pix_in = 8'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(pix_ready), 32'd0);
            check("bp_out_hold", 32'(out_pix), 32'd42);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_pix", 32'(out_pix), 32'd248);
        for (int i = 0; i < NPIX - 5; i++) send_pix(8'($urandom_range(0, 255)));
        wait_done(1'b0, dc);

        // 4: stalled load, readback spread across the table
        load_lut(2, 1'b1);
        for (int i = 0; i < NPIX; i++) send_pix(8'(i * 17));
        wait_done(1'b0, dc);

        // 5: full-throughput frame, 17th pixel refused
        load_lut(0, 1'b0);
        c0 = cyc;
        for (int i = 0; i < NPIX; i++) send_pix(8'($urandom_range(0, 255)));
        pix_valid = 1'b1;
        pix_in = 8'd99;
        wait_done(1'b1, dc);
        pix_valid = 1'b0;
        check("frame_latency", 32'(dc - c0), 32'(NPIX + 1));

        // 6: reset mid-run, reload with a new table
        load_lut(1, 1'b0);
        for (int i = 0; i < 5; i++) send_pix(8'($urandom_range(0, 255)));
        reset = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        check("mid_rst_state", 32'(state), 32'h1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_pix", 32'(out_pix), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
        reset = 1'b0;
        load_lut(3, 1'b0);
        send_pix(8'd100); check("new_lut_sat", 32'(out_pix), 32'd255);
        send_pix(8'd20);  check("new_lut_val", 32'(out_pix), 32'd60);
        for (int i = 0; i < NPIX - 2; i++) send_pix(8'($urandom_range(0, 255)));
        wait_done(1'b0, dc);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/he_lut_apply.md
Name: he_lut_apply

Overview:
- Downstream consumer of the histogram-equalization LUT stream: loads the 256 mapping entries emitted one per cycle by the HE calculator's output phase into a local table.
- Then remaps a full frame of 8-bit grayscale pixels through that table.
- Delivers the remapped pixels on a valid/ready stream to the output frame memory writer.
- Sits between the HE calculator and the destination image buffer.

Parameters:
- DWIDTH, 8, pixel width.
- AWIDTH, 21, width of incoming LUT words.
- MAX_VALUE, 256, number of LUT entries (2^DWIDTH).
- TOTAL_PIX, 1091840, pixels per frame to remap.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a LUT-load plus frame-remap pass; sampled only in IDLE.
- lut_valid  input  1  lut_in carries the next LUT entry, in index order 0..MAX_VALUE-1.
- lut_in  input  AWIDTH  LUT entry value (HE output level).
- pix_valid  input  1  pix_in valid.
- pix_in  input  DWIDTH  source pixel.
- pix_ready  output  1  block accepts pix_in this cycle.
- out_valid  output  1  out_pix valid.
- out_pix  output  DWIDTH  remapped pixel.
- out_ready  input  1  downstream accepts out_pix.
- done  output  1  one-cycle pulse when the final pixel of the frame is accepted downstream.
- state  output  4  one-hot FSM state: IDLE=0001, LOAD=0010, RUN=0100, DONE=1000.

Behaviour:
- Reset (synchronous): state=IDLE, pix_ready=0, out_valid=0, out_pix=0, done=0, lut_cnt=0, pix_cnt=0, out_cnt=0. LUT storage is not cleared; its contents are don't-care until reloaded.
- IDLE:
  - start=1 -> LOAD next cycle; lut_cnt cleared.
  - lut_valid, pix_valid and out_ready are ignored.
- LOAD:
  - Each cycle with lut_valid=1: lut[lut_cnt] <= sat(lut_in), lut_cnt++.
  - sat(x) = x if x <= MAX_VALUE-1, else MAX_VALUE-1 (e.g. 21'd300 -> 8'd255).
  - Cycles with lut_valid=0 are stalls; lut_cnt holds.
  - When the entry at lut_cnt=MAX_VALUE-1 is written -> RUN next cycle; pix_cnt and out_cnt cleared.
  - pix_ready=0 throughout LOAD.
- RUN:
  - pix_ready = (pix_cnt < TOTAL_PIX) && (!out_valid || out_ready). This is combinational from out_ready and registered state.
  - Input handshake is pix_valid && pix_ready. On a handshake: out_pix <= lut[pix_in], out_valid <= 1, pix_cnt++. Latency is exactly 1 cycle from input handshake to out_valid.
  - Output handshake is out_valid && out_ready. If there is no simultaneous input handshake, out_valid <= 0. In all cases out_cnt++.
  - Simultaneous input and output handshake: out_valid stays 1 and out_pix takes the new value. This gives full throughput of 1 pixel/cycle.
  - While out_valid=1 and out_ready=0: out_pix and out_valid hold stable and pix_ready=0.
  - When the output handshake makes out_cnt reach TOTAL_PIX -> DONE next cycle.
  - Once pix_cnt=TOTAL_PIX, pix_ready=0; extra input pixels are not accepted.
- DONE:
  - done=1 for exactly this one cycle; out_valid=0.
  - Unconditionally returns to IDLE next cycle.
- Counters: lut_cnt is 9 bits; pix_cnt and out_cnt are AWIDTH bits. No wrap occurs within a frame.
- start asserted outside IDLE is ignored.
- Reset mid-operation (any state) -> IDLE next cycle with the reset values above. Any partially loaded LUT or in-flight pixel is discarded.
- The LUT read is registered only at out_pix. The table may be implemented as distributed RAM or flops, with a single write port and a single asynchronous read port.

Test Plan:
1. Identity load: reset, start, LUT stream lut_in[i]=i contiguous for 256 cycles -> state goes 0001->0010 (256 cycles)->0100. Then feed pixels 0,17,255 with out_ready=1 -> out_pix 0,17,255, each 1 cycle after its handshake.
2. Saturation and inversion: LUT lut_in[i]=255-i, except lut_in[10]=21'd1000 -> pixel 10 gives 255, pixel 0 gives 255, pixel 200 gives 55.
3. Backpressure: in RUN with out_valid=1 (out_pix=42), hold out_ready=0 for 5 cycles -> pix_ready=0 and out_pix=42 stable for all 5 cycles. Release out_ready -> pixel is consumed and the next input is accepted in the same cycle.
4. LUT stalls: lut_valid toggled 1,0,0,1,... over the load -> RUN is entered only after the 256th valid entry, and all entries are correct by readback through pixels 0..255.
5. Frame completion (bench override TOTAL_PIX=16): stream 16 pixels with continuous valid/ready -> 16 outputs, then done=1 for exactly one cycle, then state=0001. A 17th pix_valid is never accepted (pix_ready=0).
6. Reset mid-RUN after 5 pixels, then restart with a new LUT -> outputs are zero and state is IDLE the cycle after reset. The new pass maps through the new LUT only, and pix_cnt restarts at 0.
